// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM states and op-class helper shared by alu_seq and its decoder.
package alu_seq_pkg;
    localparam int XLEN_DEFAULT = 32;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    function automatic logic is_muldiv(input logic [4:0] op);
        return op >= OP_MUL && op <= OP_REMU;
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue-side and writeback-side valid/ready bus of alu_seq.
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            carry;
    logic            illegal;
    modport master (
        output in_valid, op, data1, data2, out_ready,
        input  in_ready, out_valid, result, zero, carry, illegal
    );
    modport slave (
        input  in_valid, op, data1, data2, out_ready,
        output in_ready, out_valid, result, zero, carry, illegal
    );
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// alu_seq_muldiv_iter: XLEN-cycle shift-add multiplier / restoring divider on operand magnitudes.
// Only built with ALU_MULDIV_EN; the final iteration and sign fix-up share one edge.
`ifdef ALU_MULDIV_EN
module alu_seq_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            busy_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] res_o
);
    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);
    logic [2*XLEN-1:0] p_q, p_d, p_n, pf;
    logic [XLEN-1:0]   mb_q, mb_d, ma, mb, rem_sub;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic              neg_p_q, neg_p_d, neg_r_q, neg_r_d, sa, sb, div_op, div_q, ge;
    logic [XLEN:0]     msum;
    assign div_op  = op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign div_q   = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign sa      = op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM} && a_i[XLEN-1];
    assign sb      = op_i inside {OP_MULH, OP_DIV, OP_REM} && b_i[XLEN-1];
    assign ma      = sa ? -a_i : a_i;
    assign mb      = sb ? -b_i : b_i;
    assign msum    = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, mb_q} : '0);
    assign ge      = p_q[2*XLEN-1:XLEN-1] >= {1'b0, mb_q};
    assign rem_sub = p_q[2*XLEN-2:XLEN-1] - mb_q;
    assign p_n     = div_q ? (ge ? {rem_sub, p_q[XLEN-2:0], 1'b1} : {p_q[2*XLEN-2:0], 1'b0})
                           : {msum, p_q[XLEN-1:1]};
    assign pf      = neg_p_q ? -p_n : p_n;
    assign done_o  = cnt_q == LAST;
    always_comb begin
        p_d     = p_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        if (start_i) begin
            p_d     = {{XLEN{1'b0}}, ma};
            mb_d    = mb;
            cnt_d   = '0;
            op_d    = op_i;
            // divide by zero keeps the all-ones quotient unsigned
            neg_p_d = (sa ^ sb) && !(div_op && b_i == '0);
            neg_r_d = sa;
        end else if (busy_i) begin
            p_d   = p_n;
            cnt_d = cnt_q + SHW'(1);
        end
    end
    always_comb begin
        res_o = neg_r_q ? -p_n[2*XLEN-1:XLEN] : p_n[2*XLEN-1:XLEN];
        if (op_q == OP_MUL) res_o = pf[XLEN-1:0];
        else if (op_q inside {OP_MULH, OP_MULHSU, OP_MULHU}) res_o = pf[2*XLEN-1:XLEN];
        else if (op_q inside {OP_DIV, OP_DIVU}) res_o = neg_p_q ? -p_n[XLEN-1:0] : p_n[XLEN-1:0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q     <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
        end
    end
endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV-I ALU with registered single-cycle results.
// Define ALU_MULDIV_EN to add the iterative RV-M engine; otherwise RV-M codes are illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d, alu_res, md_res;
    logic            zero_q, zero_d, carry_q, carry_d, illegal_q, illegal_d;
    logic            alu_carry, alu_ill, accept, slt, md_op, md_done;
    logic [XLEN:0]   sum, diff;
    logic [SHW-1:0]  sh;
    assign bus.in_ready  = state_q == S_IDLE || (state_q == S_DONE && bus.out_ready);
    assign bus.out_valid = state_q == S_DONE;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.illegal   = illegal_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign sum           = {1'b0, bus.data1} + {1'b0, bus.data2};
    assign diff          = {1'b0, bus.data1} - {1'b0, bus.data2};
    assign sh            = bus.data2[SHW-1:0];
    assign slt           = $signed(bus.data1) < $signed(bus.data2);
`ifdef ALU_MULDIV_EN
    assign md_op = is_muldiv(bus.op);
    alu_seq_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start_i(accept && md_op),
        .busy_i (state_q == S_BUSY),
        .op_i   (bus.op),
        .a_i    (bus.data1),
        .b_i    (bus.data2),
        .done_o (md_done),
        .res_o  (md_res)
    );
`else
    assign md_op   = 1'b0;
    assign md_done = 1'b0;
    assign md_res  = '0;
`endif
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ill   = 1'b0;
        case (bus.op)
            OP_ADD:  {alu_carry, alu_res} = sum;
            OP_SUB:  {alu_carry, alu_res} = diff;
            OP_SLL:  alu_res = bus.data1 << sh;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, diff[XLEN]};
            OP_XOR:  alu_res = bus.data1 ^ bus.data2;
            OP_SRL:  alu_res = bus.data1 >> sh;
            OP_SRA:  alu_res = $unsigned($signed(bus.data1) >>> sh);
            OP_OR:   alu_res = bus.data1 | bus.data2;
            OP_AND:  alu_res = bus.data1 & bus.data2;
            default: alu_ill = 1'b1;
        endcase
    end
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        illegal_d = illegal_q;
        if (state_q == S_BUSY) begin
            if (md_done) begin
                state_d   = S_DONE;
                result_d  = md_res;
                zero_d    = md_res == '0;
                carry_d   = 1'b0;
                illegal_d = 1'b0;
            end
        end else if (accept) begin
            state_d = md_op ? S_BUSY : S_DONE;
            if (!md_op) begin
                result_d  = alu_res;
                zero_d    = alu_res == '0;
                carry_d   = alu_carry;
                illegal_d = alu_ill;
            end
        end else if (state_q == S_DONE && bus.out_ready) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at XLEN=32; RV-M checks follow ALU_MULDIV_EN.
module tb_alu_seq;
    import alu_seq_pkg::*;
    localparam int XLEN = 32;
    typedef struct packed { logic [31:0] r; logic z; logic c; logic i; } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t mon_got, mon_exp;
    alu_seq_if #(.XLEN(XLEN)) bi ();
    alu_seq #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bi));
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] w;
        logic [63:0] p;
        logic [4:0]  s;
        s = b[4:0];
        e = '0;
        w = '0;
        p = '0;
        case (op)
            OP_ADD:  begin w = {1'b0, a} + {1'b0, b}; e.r = w[31:0]; e.c = w[32]; end
            OP_SUB:  begin e.r = a - b; e.c = a < b; end
            OP_SLL:  e.r = a << s;
            OP_SLT:  e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: e.r = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  e.r = a ^ b;
            OP_SRL:  e.r = a >> s;
            OP_SRA:  e.r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            OP_OR:   e.r = a | b;
            OP_AND:  e.r = a & b;
`ifdef ALU_MULDIV_EN
            OP_MUL:    begin p = {32'h0, a} * {32'h0, b}; e.r = p[31:0]; end
            OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; e.r = p[63:32]; end
            OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'h0, b}; e.r = p[63:32]; end
            OP_MULHU:  begin p = {32'h0, a} * {32'h0, b}; e.r = p[63:32]; end
            OP_DIV:    e.r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a
                             : $unsigned($signed(a) / $signed(b));
            OP_DIVU:   e.r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    e.r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0
                             : $unsigned($signed(a) % $signed(b));
            OP_REMU:   e.r = (b == 0) ? a : a % b;
`endif
            default: e.i = 1'b1;
        endcase
        e.z = e.r == 32'h0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && bi.out_valid && bi.out_ready) begin
            mon_got = {bi.result, bi.zero, bi.carry, bi.illegal};
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_extra: result=%h with no expected entry", mon_got.r);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL scoreboard: got r=%h z=%b c=%b i=%b want r=%h z=%b c=%b i=%b",
                             mon_got.r, mon_got.z, mon_got.c, mon_got.i, mon_exp.r, mon_exp.z, mon_exp.c, mon_exp.i);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        bi.in_valid = 1'b1;
        bi.op = op;
        bi.data1 = a;
        bi.data2 = b;
        @(negedge clk);
        while (!bi.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!bi.in_ready) begin
            miscompares++;
            $display("FAIL accept_timeout: in_ready=%b want 1 after %0d cycles", bi.in_ready, n);
        end else sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bi.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        vectors += 6;
        if (bi.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bi.out_valid); end
        if (bi.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bi.in_ready); end
        if (bi.result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h want 0", bi.result); end
        if (bi.zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero: got %b want 0", bi.zero); end
        if (bi.carry !== 1'b0) begin miscompares++; $display("FAIL reset_carry: got %b want 0", bi.carry); end
        if (bi.illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", bi.illegal); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_alu_ops();
        logic [4:0]  ops [12] = '{OP_SLT, OP_SLTU, OP_SRA, OP_SUB, OP_SUB, OP_SLL, OP_SRL,
                                  OP_XOR, OP_OR, OP_AND, 5'd20, 5'd31};
        logic [31:0] as  [12] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd3, 32'd5, 32'h0000_0001,
                                  32'h8000_0000, 32'hF0F0_1234, 32'h0F00_0001, 32'hFFFF_00FF, 32'd9, 32'd9};
        logic [31:0] bs  [12] = '{32'd1, 32'd1, 32'd31, 32'd5, 32'd5, 32'h0000_0023,
                                  32'h0000_0024, 32'hFF00_1234, 32'h00F0_0010, 32'h0F0F_FF00, 32'd4, 32'd4};
        send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        vectors += 3;
        if (bi.out_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: out_valid=%b want 1", bi.out_valid); end
        if (bi.zero !== 1'b1) begin miscompares++; $display("FAIL add_zero: got %b want 1", bi.zero); end
        if (bi.carry !== 1'b1) begin miscompares++; $display("FAIL add_carry: got %b want 1", bi.carry); end
        for (int i = 0; i < 12; i++) send(ops[i], as[i], bs[i]);
        step(1);
        vectors += 2;
        if (bi.illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_flag: got %b want 1", bi.illegal); end
        if (bi.result !== 32'h0) begin miscompares++; $display("FAIL illegal_result: got %h want 0", bi.result); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            send(5'($urandom_range(0, 9)), $urandom(),
                 ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 40)));
        step(2);
    endtask

    task automatic test_back_to_back();
        exp_t e1 = model(OP_XOR, 32'hDEAD_BEEF, 32'h1234_5678);
        exp_t e2 = model(OP_ADD, 32'd5, 32'd7);
        step(2);
        bi.out_ready = 1'b0;
        send(OP_XOR, 32'hDEAD_BEEF, 32'h1234_5678);
        bi.in_valid = 1'b1;
        bi.op = OP_ADD;
        bi.data1 = 32'd5;
        bi.data2 = 32'd7;
        for (int i = 0; i < 5; i++) begin
            step(1);
            vectors += 3;
            if (bi.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid: got %b want 1", bi.out_valid); end
            if (bi.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready: got %b want 0", bi.in_ready); end
            if ({bi.result, bi.zero, bi.carry, bi.illegal} !== e1) begin
                miscompares++;
                $display("FAIL stall_hold: got r=%h want r=%h", bi.result, e1.r);
            end
        end
        bi.out_ready = 1'b1;
        #1;
        vectors++;
        if (bi.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready: got %b want 1", bi.in_ready); end
        sb.push_back(e2);
        step(1);
        bi.in_valid = 1'b0;
        vectors += 2;
        if (bi.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b want 1", bi.out_valid); end
        if (bi.result !== 32'd12) begin miscompares++; $display("FAIL b2b_result: got %h want 0000000c", bi.result); end
        step(2);
    endtask

    task automatic test_reset_in_flight();
        step(2);
        bi.out_ready = 1'b0;
        send(OP_ADD, 32'd1, 32'd2);
        reset = 1'b1;
        sb.delete();
        step(1);
        reset = 1'b0;
        bi.out_ready = 1'b1;
        vectors += 2;
        if (bi.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_done_valid: got %b want 0", bi.out_valid); end
        if (bi.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_done_in_ready: got %b want 1", bi.in_ready); end
`ifdef ALU_MULDIV_EN
        begin
            logic seen = 1'b0;
            send(OP_DIV, 32'd1000, 32'd3);
            step(9);
            reset = 1'b1;
            sb.delete();
            step(1);
            reset = 1'b0;
            vectors += 2;
            if (bi.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_busy_valid: got %b want 0", bi.out_valid); end
            if (bi.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_busy_in_ready: got %b want 1", bi.in_ready); end
            for (int i = 0; i < 40; i++) begin
                step(1);
                seen = seen | bi.out_valid;
            end
            vectors++;
            if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_busy_discard: out_valid seen=%b want 0", seen); end
        end
`endif
        step(1);
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_muldiv();
        logic [4:0]  ops [11] = '{OP_MULHU, OP_MUL, OP_MULHSU, OP_DIV, OP_REM, OP_DIV, OP_REM,
                                  OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as  [11] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'h8000_0000,
                                  32'h8000_0000, 32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] bs  [11] = '{32'hFFFF_FFFF, 32'h9ABC_DEF0, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'd7, 32'd7, 32'd2, 32'd2};
        int n = 1;
        send(OP_MULH, 32'h8000_0000, 32'h8000_0000);
        while (!bi.out_valid && n < 100) begin
            step(1);
            n++;
        end
        vectors += 2;
        if (n != 33) begin miscompares++; $display("FAIL mulh_latency: got %0d edges want 33", n); end
        if (bi.result !== 32'h4000_0000) begin miscompares++; $display("FAIL mulh_result: got %h want 40000000", bi.result); end
        for (int i = 0; i < 11; i++) send(ops[i], as[i], bs[i]);
        for (int i = 0; i < 6; i++) send(5'($urandom_range(10, 17)), $urandom(), $urandom());
        step(40);
    endtask
`else
    task automatic test_muldiv();
        send(OP_MUL, 32'd3, 32'd4);
        vectors += 3;
        if (bi.out_valid !== 1'b1) begin miscompares++; $display("FAIL mul_off_latency: out_valid=%b want 1", bi.out_valid); end
        if (bi.illegal !== 1'b1) begin miscompares++; $display("FAIL mul_off_illegal: got %b want 1", bi.illegal); end
        if (bi.result !== 32'h0) begin miscompares++; $display("FAIL mul_off_result: got %h want 0", bi.result); end
        step(2);
    endtask
`endif

    initial begin
        bi.in_valid = 1'b0;
        bi.op = OP_ADD;
        bi.data1 = '0;
        bi.data2 = '0;
        bi.out_ready = 1'b1;
        test_reset();
        test_alu_ops();
        test_random();
        test_back_to_back();
        test_muldiv();
        test_reset_in_flight();
        step(3);
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: %0d results missing want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational integer ALU for the RV32/RV64 execute stage. It sits between decode/issue and writeback and performs RV-I arithmetic, logic and shift ops with one-cycle registered latency. It adds correct signed/unsigned compare and, optionally, the RV-M multiply/divide family on an iterative XLEN-cycle engine. A valid/ready handshake on both sides lets the pipeline stall while a multi-cycle op is in flight.

## Interface
- XLEN, 32: datapath width; 32 or 64 only.
- SHW, $clog2(XLEN): shift-amount width.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block accepts on in_valid && in_ready.
- op  in  5  decoded op code (shared constants): ADD SUB SLL SLT SLTU XOR SRL SRA OR AND MUL MULH MULHSU MULHU DIV DIVU REM REMU.
- data1, data2  in  XLEN  rs1 / rs2-or-immediate operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result on out_valid && out_ready.
- result  out  XLEN  registered result.
- zero  out  1  result == 0.
- carry  out  1  ADD carry-out / SUB borrow (data1 < data2 unsigned); 0 for all other ops.
- illegal  out  1  op code unsupported; qualifies result, which is 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On accept:
  - Single-cycle op: compute, register result/zero/carry, go to DONE.
  - MUL*/DIV*/REM*: latch operands, go to BUSY.
- BUSY: in_ready=0. Iterative engine, one bit per cycle, XLEN cycles. Then sign fix-up and register, go to DONE.
- DONE: out_valid=1, outputs held stable. On out_ready, return to IDLE.
  - in_ready = out_ready in DONE. A new op may be accepted in the same cycle the result is taken (back-to-back).
- Shifts use data2[SHW-1:0]. SRA is arithmetic on a signed operand.
- SLT is signed compare; SLTU is unsigned.
- MULH/MULHSU/MULHU return the upper XLEN bits of the 2·XLEN product; MUL returns the lower XLEN bits.
- Divide by zero: quotient all-ones, remainder = data1.
- Signed overflow (most-negative / −1): quotient = data1, remainder = 0.
- Undefined op codes: result=0, zero=1, carry=0, illegal=1, single-cycle latency.

## Timing
- Reset values: state IDLE; out_valid 0; result 0; zero 0; carry 0; illegal 0; engine counter 0.
- in_ready is 1 out of reset.
- Single-cycle op accepted at edge N: out_valid is high after edge N+1.
- Iterative op accepted at edge N: out_valid is high after edge N+XLEN+1. Fixed latency, independent of operand values; no early-out.
- out_valid held with out_ready low: result, zero, carry and illegal must not change.
- Reset asserted in BUSY or DONE: the in-flight op is discarded, no result is produced, and the block is in IDLE on the next cycle.
- in_valid while in_ready=0 is ignored. The producer holds its inputs.

## Configuration
- ALU_MULDIV_EN defined: RV-M ops are executed as above.
- ALU_MULDIV_EN undefined: RV-M op codes are treated as undefined (illegal=1, single-cycle, result 0). The BUSY state and the engine are not synthesised.

## Structure
- Shared constants go in the existing macro include: op codes, XLEN defaults, funct-to-op mapping constants. The decoder uses the same include.
- One sub-module, muldiv_iter: handles operand sign capture, the shift-add multiplier, the restoring divider, the cycle counter and the final negation.
- alu_seq owns the FSM, the single-cycle datapath and the output registers.

## Test plan
- XLEN=32, ADD 0xFFFFFFFF+1 -> result 0, zero 1, carry 1, out_valid one cycle after accept.
- SLT 0x80000000 vs 1 -> 1. SLTU, same operands -> 0. SRA 0x80000000 by 31 -> 0xFFFFFFFF.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. out_valid rises 33 edges after accept.
- DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM, same operands -> 0.
- out_ready held low for 5 cycles in DONE -> outputs stable and in_ready=0. Then release out_ready together with a new in_valid ADD -> accepted that cycle, next result one cycle later.
- reset pulsed at cycle 10 of a DIV -> out_valid stays 0 and in_ready=1 next cycle. With ALU_MULDIV_EN undefined, MUL -> illegal 1, result 0, 1-cycle latency.
